// File: rtl/pn_engine_if.sv
// Configuration bus for pn_engine: one write per strobe selects an item by kind,
// transition and place index.
interface pn_engine_if #(
    parameter int NUM_PLACES = 48,
    parameter int NUM_TRANS  = 40,
    parameter int TOK_W      = 8
);
    localparam int PW = (NUM_PLACES > 1) ? $clog2(NUM_PLACES) : 1;
    localparam int TW = (NUM_TRANS > 1) ? $clog2(NUM_TRANS) : 1;

    logic             cfg_we;
    logic [1:0]       cfg_kind;
    logic [TW-1:0]    cfg_trans;
    logic [PW-1:0]    cfg_place;
    logic [TOK_W-1:0] cfg_data;

    modport master (
        output cfg_we, cfg_kind, cfg_trans, cfg_place, cfg_data
    );

    modport slave (
        input cfg_we, cfg_kind, cfg_trans, cfg_place, cfg_data
    );
endinterface

// File: rtl/pn_engine.sv
// Runtime-programmable Petri-net token machine: one batch firing every two cycles.
// Optional macro PN_TRACE_EN adds trace_valid/trace_idx/trace_amt outputs.
module pn_engine #(
    parameter int NUM_PLACES = 48,
    parameter int NUM_TRANS  = 40,
    parameter int TOK_W      = 8,
    parameter int LED_PLACE  = 45,
    parameter int CNT_W      = 16,
    localparam int PW = (NUM_PLACES > 1) ? $clog2(NUM_PLACES) : 1,
    localparam int TW = (NUM_TRANS > 1) ? $clog2(NUM_TRANS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    pn_engine_if.slave       cfg,
    input  logic             start,
    input  logic             stop,
    input  logic [PW-1:0]    obs_sel,
    output logic [TOK_W-1:0] obs_tokens,
    output logic             busy,
    output logic             dead,
    output logic [CNT_W-1:0] fire_cnt,
`ifdef PN_TRACE_EN
    output logic             trace_valid,
    output logic [TW-1:0]    trace_idx,
    output logic [TOK_W-1:0] trace_amt,
`endif
    output logic [5:0]       led
);
    // An out-of-range LED_PLACE falls back to place 0 rather than indexing past the array.
    localparam int LP = (LED_PLACE < NUM_PLACES) ? LED_PLACE : 0;
    localparam logic [TOK_W-1:0] TOK_MAX = {TOK_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_FIRE = 2'd2,
        S_DEAD = 2'd3
    } state_t;

    state_t                state_r;
    logic [TOK_W-1:0]      tok_r      [NUM_PLACES];
    logic [TOK_W-1:0]      init_r     [NUM_PLACES];
    logic [NUM_PLACES-1:0] in_mask_r  [NUM_TRANS];
    logic [NUM_PLACES-1:0] out_mask_r [NUM_TRANS];
    logic [NUM_TRANS-1:0]  cls_r;
    logic [TW-1:0]         win_idx_r;
    logic [TOK_W-1:0]      win_amt_r;
    logic [CNT_W-1:0]      fire_cnt_r;
    logic [TOK_W-1:0]      obs_tokens_r;
    logic [5:0]            led_r;
    logic                  busy_r;
    logic                  dead_r;
    logic                  trace_valid_r;
    logic [TW-1:0]         trace_idx_r;
    logic [TOK_W-1:0]      trace_amt_r;

    logic                  wr_en_s;
    logic                  place_ok_s;
    logic                  trans_ok_s;
    logic                  wr_init_s;
    logic                  wr_in_s;
    logic                  wr_out_s;
    logic                  wr_cls_s;
    logic [TOK_W-1:0]      init_nxt_s [NUM_PLACES];
    logic [TOK_W-1:0]      f_s        [NUM_TRANS];
    logic [NUM_TRANS-1:0]  en_s;
    logic                  hit0_s;
    logic                  hit1_s;
    logic [TW-1:0]         idx0_s;
    logic [TW-1:0]         idx1_s;
    logic                  found_s;
    logic [TW-1:0]         sel_idx_s;
    logic [TOK_W-1:0]      sel_amt_s;
    logic [TOK_W-1:0]      sub_s      [NUM_PLACES];
    logic [TOK_W-1:0]      add_s      [NUM_PLACES];
    logic [TOK_W-1:0]      diff_s     [NUM_PLACES];
    logic [TOK_W:0]        sum_s      [NUM_PLACES];
    logic [TOK_W-1:0]      fire_tok_s [NUM_PLACES];
    logic [CNT_W-1:0]      cnt_inc_s;
    logic                  obs_ok_s;

    // Config write decode; the init image includes a same-cycle write so start sees it.
    always_comb begin
        wr_en_s    = cfg.cfg_we && (state_r == S_IDLE);
        place_ok_s = (32'(cfg.cfg_place) < NUM_PLACES);
        trans_ok_s = (32'(cfg.cfg_trans) < NUM_TRANS);
        wr_init_s  = wr_en_s && (cfg.cfg_kind == 2'd0) && place_ok_s;
        wr_in_s    = wr_en_s && (cfg.cfg_kind == 2'd1) && place_ok_s && trans_ok_s;
        wr_out_s   = wr_en_s && (cfg.cfg_kind == 2'd2) && place_ok_s && trans_ok_s;
        wr_cls_s   = wr_en_s && (cfg.cfg_kind == 2'd3) && trans_ok_s;
        for (int p = 0; p < NUM_PLACES; p++) begin
            init_nxt_s[p] = (wr_init_s && (cfg.cfg_place == PW'(p))) ? cfg.cfg_data : init_r[p];
        end
    end

    // Firing amount per transition: min token count over its input places.
    always_comb begin
        for (int t = 0; t < NUM_TRANS; t++) begin
            f_s[t] = TOK_MAX;
            for (int p = 0; p < NUM_PLACES; p++) begin
                f_s[t] = (in_mask_r[t][p] && (tok_r[p] < f_s[t])) ? tok_r[p] : f_s[t];
            end
            en_s[t] = (|in_mask_r[t]) && (f_s[t] != {TOK_W{1'b0}});
        end
    end

    // Winner: lowest-index enabled class-0 transition, else lowest-index class-1.
    always_comb begin
        hit0_s = 1'b0;
        hit1_s = 1'b0;
        idx0_s = {TW{1'b0}};
        idx1_s = {TW{1'b0}};
        for (int t = NUM_TRANS - 1; t >= 0; t--) begin
            hit0_s = hit0_s | (en_s[t] & ~cls_r[t]);
            hit1_s = hit1_s | (en_s[t] & cls_r[t]);
            idx0_s = (en_s[t] && !cls_r[t]) ? TW'(t) : idx0_s;
            idx1_s = (en_s[t] && cls_r[t]) ? TW'(t) : idx1_s;
        end
        found_s   = hit0_s | hit1_s;
        sel_idx_s = hit0_s ? idx0_s : idx1_s;
        sel_amt_s = f_s[sel_idx_s];
    end

    // Next marking for the registered winner; subtract first, then saturating add.
    always_comb begin
        for (int p = 0; p < NUM_PLACES; p++) begin
            sub_s[p]      = in_mask_r[win_idx_r][p] ? win_amt_r : {TOK_W{1'b0}};
            add_s[p]      = out_mask_r[win_idx_r][p] ? win_amt_r : {TOK_W{1'b0}};
            diff_s[p]     = tok_r[p] - sub_s[p];
            sum_s[p]      = {1'b0, diff_s[p]} + {1'b0, add_s[p]};
            fire_tok_s[p] = sum_s[p][TOK_W] ? TOK_MAX : sum_s[p][TOK_W-1:0];
        end
        cnt_inc_s = (fire_cnt_r == CNT_MAX) ? fire_cnt_r : fire_cnt_r + CNT_W'(1);
        obs_ok_s  = (32'(obs_sel) < NUM_PLACES);
    end

    // Configuration storage: masks, priority classes and initial marking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TRANS; t++) begin
                in_mask_r[t]  <= {NUM_PLACES{1'b0}};
                out_mask_r[t] <= {NUM_PLACES{1'b0}};
            end
            cls_r <= {NUM_TRANS{1'b0}};
            for (int p = 0; p < NUM_PLACES; p++) begin
                init_r[p] <= {TOK_W{1'b0}};
            end
        end else begin
            for (int p = 0; p < NUM_PLACES; p++) begin
                init_r[p] <= init_nxt_s[p];
            end
            if (wr_in_s) begin
                in_mask_r[cfg.cfg_trans][cfg.cfg_place] <= cfg.cfg_data[0];
            end
            if (wr_out_s) begin
                out_mask_r[cfg.cfg_trans][cfg.cfg_place] <= cfg.cfg_data[0];
            end
            if (wr_cls_s) begin
                cls_r[cfg.cfg_trans] <= cfg.cfg_data[0];
            end
        end
    end

    // Control FSM with live marking, winner latch, firing counter and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            win_idx_r     <= {TW{1'b0}};
            win_amt_r     <= {TOK_W{1'b0}};
            fire_cnt_r    <= {CNT_W{1'b0}};
            busy_r        <= 1'b0;
            dead_r        <= 1'b0;
            trace_valid_r <= 1'b0;
            trace_idx_r   <= {TW{1'b0}};
            trace_amt_r   <= {TOK_W{1'b0}};
            for (int p = 0; p < NUM_PLACES; p++) begin
                tok_r[p] <= {TOK_W{1'b0}};
            end
        end else begin
            trace_valid_r <= 1'b0;
            case (state_r)
                S_IDLE, S_DEAD: begin
                    if (stop) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                        dead_r  <= 1'b0;
                    end else if (start) begin
                        for (int p = 0; p < NUM_PLACES; p++) begin
                            tok_r[p] <= init_nxt_s[p];
                        end
                        fire_cnt_r <= {CNT_W{1'b0}};
                        state_r    <= S_EVAL;
                        busy_r     <= 1'b1;
                        dead_r     <= 1'b0;
                    end
                end
                S_EVAL: begin
                    if (stop) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end else if (found_s) begin
                        win_idx_r     <= sel_idx_s;
                        win_amt_r     <= sel_amt_s;
                        trace_valid_r <= 1'b1;
                        trace_idx_r   <= sel_idx_s;
                        trace_amt_r   <= sel_amt_s;
                        state_r       <= S_FIRE;
                    end else begin
                        state_r <= S_DEAD;
                        busy_r  <= 1'b0;
                        dead_r  <= 1'b1;
                    end
                end
                S_FIRE: begin
                    for (int p = 0; p < NUM_PLACES; p++) begin
                        tok_r[p] <= fire_tok_s[p];
                    end
                    fire_cnt_r <= cnt_inc_s;
                    state_r    <= stop ? S_IDLE : S_EVAL;
                    busy_r     <= ~stop;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    dead_r  <= 1'b0;
                end
            endcase
        end
    end

    // Observation port and LED drive, one cycle behind the live marking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            obs_tokens_r <= {TOK_W{1'b0}};
            led_r        <= 6'h3F;
        end else begin
            obs_tokens_r <= obs_ok_s ? tok_r[obs_sel] : {TOK_W{1'b0}};
            led_r        <= ~tok_r[LP][5:0];
        end
    end

    assign obs_tokens = obs_tokens_r;
    assign busy       = busy_r;
    assign dead       = dead_r;
    assign fire_cnt   = fire_cnt_r;
    assign led        = led_r;

`ifdef PN_TRACE_EN
    assign trace_valid = trace_valid_r;
    assign trace_idx   = trace_idx_r;
    assign trace_amt   = trace_amt_r;
`else
    logic unused_trace_s;
    assign unused_trace_s = ^{trace_valid_r, trace_idx_r, trace_amt_r};
`endif
endmodule
